// File: rtl/immgen_pipe.sv
// Registered immediate generator for the decode stage: decodes the format from the opcode,
// builds an XLEN-wide immediate and passes it through a two-entry main/skid valid/ready buffer.
module immgen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [6:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit Rv64 = (XLEN == 64);

    localparam logic [6:0] FmtR = 7'b0000001;
    localparam logic [6:0] FmtI = 7'b0000010;
    localparam logic [6:0] FmtS = 7'b0000100;
    localparam logic [6:0] FmtB = 7'b0001000;
    localparam logic [6:0] FmtU = 7'b0010000;
    localparam logic [6:0] FmtJ = 7'b0100000;
    localparam logic [6:0] FmtZ = 7'b1000000;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign imm_i = {{20{in_insn[31]}}, in_insn[31:20]};
    assign imm_s = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    assign imm_b = {{20{in_insn[31]}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
    assign imm_u = {in_insn[31:12], 12'b0};
    assign imm_j = {{12{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
    assign imm_z = {27'b0, in_insn[19:15]};

    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [6:0]      dec_fmt;
    logic            dec_ill;

    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = '0;
        dec_ill   = 1'b0;
        case (in_insn[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                dec_fmt   = FmtI;
                dec_imm32 = imm_i;
            end
            7'b0011011: begin
                if (Rv64) begin
                    dec_fmt   = FmtI;
                    dec_imm32 = imm_i;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt   = FmtS;
                dec_imm32 = imm_s;
            end
            7'b1100011: begin
                dec_fmt   = FmtB;
                dec_imm32 = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FmtU;
                dec_imm32 = imm_u;
            end
            7'b1101111: begin
                dec_fmt   = FmtJ;
                dec_imm32 = imm_j;
            end
            7'b0110011: dec_fmt = FmtR;
            7'b0111011: begin
                if (Rv64) dec_fmt = FmtR;
                else      dec_ill = 1'b1;
            end
            7'b1110011: begin
                if (in_insn[14]) begin
                    dec_fmt   = FmtZ;
                    dec_imm32 = imm_z;
                end else begin
                    dec_fmt = FmtR;
                end
            end
            default: dec_ill = 1'b1;
        endcase
        // Widen by replicating bit 31; Z and R values have it clear so they stay zero-extended.
        dec_imm       = {XLEN{dec_imm32[31]}};
        dec_imm[31:0] = dec_imm32;
    end

    state_e           state_q;
    logic [XLEN-1:0]  main_imm_q, skid_imm_q;
    logic [6:0]       main_fmt_q, skid_fmt_q;
    logic             main_ill_q, skid_ill_q;
    logic [TAG_W-1:0] main_tag_q, skid_tag_q;

    logic accept, pop;

    assign in_ready    = (state_q != StFull) && !reset;
    assign out_valid   = (state_q != StEmpty);
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

    assign out_imm     = main_imm_q;
    assign out_fmt     = main_fmt_q;
    assign out_illegal = main_ill_q;
    assign out_tag     = main_tag_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= StEmpty;
            main_imm_q <= '0;
            main_fmt_q <= '0;
            main_ill_q <= 1'b0;
            main_tag_q <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= '0;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q    <= StOne;
                        main_imm_q <= dec_imm;
                        main_fmt_q <= dec_fmt;
                        main_ill_q <= dec_ill;
                        main_tag_q <= in_tag;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        main_imm_q <= dec_imm;
                        main_fmt_q <= dec_fmt;
                        main_ill_q <= dec_ill;
                        main_tag_q <= in_tag;
                    end else if (pop) begin
                        // Outputs read as zero whenever nothing is held.
                        state_q    <= StEmpty;
                        main_imm_q <= '0;
                        main_fmt_q <= '0;
                        main_ill_q <= 1'b0;
                        main_tag_q <= '0;
                    end else if (accept) begin
                        state_q    <= StFull;
                        skid_imm_q <= dec_imm;
                        skid_fmt_q <= dec_fmt;
                        skid_ill_q <= dec_ill;
                        skid_tag_q <= in_tag;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_q    <= StOne;
                        main_imm_q <= skid_imm_q;
                        main_fmt_q <= skid_fmt_q;
                        main_ill_q <= skid_ill_q;
                        main_tag_q <= skid_tag_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked each
// cycle against a queue-based model, plus directed literal cases.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_insn, in_tag;

    logic        r32, v32, ill32;
    logic [31:0] imm32, tag32;
    logic [6:0]  fmt32;
    logic        r64, v64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [6:0]  fmt64;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] tag;
    } entry_t;
    entry_t q[$];

    logic [31:0] got[$];
    logic [6:0]  ops[13] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73};

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32), .in_insn(in_insn),
        .in_tag(in_tag), .flush(flush), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64), .in_insn(in_insn),
        .in_tag(in_tag), .flush(flush), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint unsigned x, input int bits);
        longint s;
        s = longint'(x << (64 - bits));
        return s >>> (64 - bits);
    endfunction

    // Reference decode: field value by format, then extended to the full width.
    function automatic void model(input logic [31:0] insn, input bit is64,
                                  output logic [63:0] imm, output logic [6:0] fmt,
                                  output logic ill);
        longint v;
        v   = 0;
        fmt = 7'd0;
        ill = 1'b0;
        case (insn[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: begin fmt = 7'd2; v = sext(insn[31:20], 12); end
            7'h1B: if (is64) begin fmt = 7'd2; v = sext(insn[31:20], 12); end else ill = 1'b1;
            7'h23: begin fmt = 7'd4; v = sext({insn[31:25], insn[11:7]}, 12); end
            7'h63: begin
                fmt = 7'd8;
                v = sext({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}, 13);
            end
            7'h37, 7'h17: begin fmt = 7'd16; v = sext({insn[31:12], 12'b0}, 32); end
            7'h6F: begin
                fmt = 7'd32;
                v = sext({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}, 21);
            end
            7'h33: fmt = 7'd1;
            7'h3B: if (is64) fmt = 7'd1; else ill = 1'b1;
            7'h73: if (insn[14]) begin fmt = 7'd64; v = longint'(insn[19:15]); end
                   else fmt = 7'd1;
            default: ill = 1'b1;
        endcase
        imm = is64 ? v : {32'b0, v[31:0]};
    endfunction

    // Per-cycle compare against the queue model, then advance the model across the edge.
    initial begin
        logic [63:0] e_imm;
        logic [6:0]  e_fmt;
        logic        e_ill;
        bit          exp_valid, exp_ready;
        entry_t      e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            exp_valid = q.size() > 0;
            exp_ready = !reset && q.size() < 2;
            check("valid32", v32, exp_valid);
            check("ready32", r32, exp_ready);
            check("valid64", v64, exp_valid);
            check("ready64", r64, exp_ready);
            if (exp_valid) begin
                model(q[0].insn, 1'b0, e_imm, e_fmt, e_ill);
                check("imm32", imm32, e_imm[31:0]);
                check("fmt32", fmt32, e_fmt);
                check("ill32", ill32, e_ill);
                check("tag32", tag32, q[0].tag);
                model(q[0].insn, 1'b1, e_imm, e_fmt, e_ill);
                check("imm64", imm64, e_imm);
                check("fmt64", fmt64, e_fmt);
                check("ill64", ill64, e_ill);
                check("tag64", tag64, q[0].tag);
            end else begin
                check("idle32", {imm32, fmt32, ill32, tag32}, 64'd0);
                check("idle64_imm", imm64, 64'd0);
                check("idle64", {fmt64, ill64, tag64}, 64'd0);
            end
            if (reset || flush) begin
                q.delete();
            end else begin
                if (exp_valid && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) begin
                    e.insn = in_insn;
                    e.tag  = in_tag;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_check(input logic [31:0] insn,
                              input logic [31:0] i32, input logic [6:0] f32, input logic l32,
                              input logic [63:0] i64, input logic [6:0] f64, input logic l64);
        in_valid  = 1'b1;
        in_insn   = insn;
        in_tag    = insn ^ 32'h5A5A_0000;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_valid", v32, 1'b1);
        check("lit_imm32", imm32, i32);
        check("lit_fmt32", fmt32, f32);
        check("lit_ill32", ill32, l32);
        check("lit_imm64", imm64, i64);
        check("lit_fmt64", fmt64, f64);
        check("lit_ill64", ill64, l64);
        check("lit_tag", tag32, insn ^ 32'h5A5A_0000);
        tick();
    endtask

    initial begin
        bit acc;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_insn = '0; in_tag = '0;
        tick();
        mon_en = 1'b1;
        check("rst_ready", r32, 1'b0);
        tick();
        check("rst_valid", v32, 1'b0);
        check("rst_outs", {imm32, fmt32, ill32, tag32}, 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", r32, 1'b1);

        send_check(32'hFFF00093, 32'hFFFFFFFF, 7'h02, 1'b0, 64'hFFFFFFFFFFFFFFFF, 7'h02, 1'b0);
        send_check(32'hFE112E23, 32'hFFFFFFFC, 7'h04, 1'b0, 64'hFFFFFFFFFFFFFFFC, 7'h04, 1'b0);
        send_check(32'hFE000CE3, 32'hFFFFFFF8, 7'h08, 1'b0, 64'hFFFFFFFFFFFFFFF8, 7'h08, 1'b0);
        send_check(32'h0010006F, 32'h00000800, 7'h20, 1'b0, 64'h800, 7'h20, 1'b0);
        send_check(32'h300FD073, 32'h0000001F, 7'h40, 1'b0, 64'h1F, 7'h40, 1'b0);
        send_check(32'h00000000, 32'h0, 7'h00, 1'b1, 64'h0, 7'h00, 1'b1);
        send_check(32'h0000001B, 32'h0, 7'h00, 1'b1, 64'h0, 7'h02, 1'b0);
        send_check(32'h800000B7, 32'h80000000, 7'h10, 1'b0, 64'hFFFFFFFF80000000, 7'h10, 1'b0);

        // Backpressure: tags 1 and 2 fill the buffer, tag 3 waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'hFFF00093;
        in_tag    = 32'd1;
        tick();
        in_tag = 32'd2;
        tick();
        in_tag = 32'd3;
        check("bp_ready_drop", r32, 1'b0);
        check("bp_head_tag", tag32, 32'd1);
        tick();
        tick();
        check("bp_hold_imm", imm32, 32'hFFFFFFFF);
        check("bp_hold_tag", tag32, 32'd1);
        check("bp_still_full", r32, 1'b0);
        out_ready = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            acc = in_valid && r32;
            if (v32) got.push_back(tag32);
            tick();
            if (acc) in_valid = 1'b0;
        end
        check("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("bp_order", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, i + 1);
        end

        // Flush while full, with a new instruction offered in the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'h0010006F;
        in_tag    = 32'h11;
        tick();
        in_tag = 32'h12;
        tick();
        flush   = 1'b1;
        in_tag  = 32'h99;
        in_insn = 32'h800000B7;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", v32, 1'b0);
        check("flush_ready", r32, 1'b1);
        check("flush_outs", {imm32, fmt32, ill32, tag32}, 64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("flush_no_ghost", v32, 1'b0);

        // Reset with one entry held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'h0010006F;
        in_tag    = 32'h21;
        tick();
        in_valid = 1'b0;
        check("one_valid", v32, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_ready32", r32, 1'b0);
        check("rst_mid_ready64", r64, 1'b0);
        tick();
        check("rst_mid_valid", v32, 1'b0);
        check("rst_mid_outs", {imm32, fmt32, ill32, tag32}, 64'd0);
        check("rst_mid_imm64", imm64, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_after", r32, 1'b1);
        send_check(32'h300FD073, 32'h0000001F, 7'h40, 1'b0, 64'h1F, 7'h40, 1'b0);

        // Randomised traffic, checked by the per-cycle compare.
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(99) == 0);
            flush     = ($urandom_range(24) == 0);
            in_valid  = $urandom_range(1) != 0;
            out_ready = ($urandom_range(3) != 0);
            in_insn   = $urandom;
            if ($urandom_range(7) != 0) in_insn[6:0] = ops[$urandom_range(12)];
            in_tag    = $urandom;
            tick();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("drain_empty", v32, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
